// File: rtl/decoder_seq_nto2n_if.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq_nto2n_if
// Brief    : Control and result bundle for the scanning one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface decoder_seq_nto2n_if #(
    parameter int N_IN    = 3,
    parameter int DWELL_W = 4
);
    localparam int c_out_w = 2 ** N_IN;

    logic               en;
    logic [1:0]         mode;
    logic [N_IN-1:0]    data_in;
    logic               load;
    logic [DWELL_W-1:0] dwell_in;
    logic [c_out_w-1:0] y_out;
    logic [N_IN-1:0]    idx_out;
    logic               valid_out;
    logic               wrap_out;

    modport master (
        output en, mode, data_in, load, dwell_in,
        input  y_out, idx_out, valid_out, wrap_out
    );

    modport slave (
        input  en, mode, data_in, load, dwell_in,
        output y_out, idx_out, valid_out, wrap_out
    );
endinterface
`default_nettype wire

// File: rtl/decoder_seq_nto2n.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq_nto2n
// Brief    : Registered N-to-2^N one-hot decoder with up/down scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_seq_nto2n #(
    parameter int N_IN       = 3,
    parameter int DWELL_W    = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    decoder_seq_nto2n_if.slave  bus
);
    localparam int c_out_w = 2 ** N_IN;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_direct  = 3'd1;
    localparam logic [2:0] c_st_scan_up = 3'd2;
    localparam logic [2:0] c_st_scan_dn = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;

    localparam logic [N_IN-1:0]    c_idx_max   = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]    c_idx_zero  = {N_IN{1'b0}};
    localparam logic [N_IN-1:0]    c_idx_one   = N_IN'(1);
    localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);
    localparam logic [c_out_w-1:0] c_one_hot0  = c_out_w'(1);
    localparam logic [c_out_w-1:0] c_idle      =
        (ACTIVE_LOW != 0) ? {c_out_w{1'b1}} : {c_out_w{1'b0}};

    logic [2:0]         r_state;
    logic [N_IN-1:0]    r_idx;
    logic [DWELL_W-1:0] r_dwell;
    logic [c_out_w-1:0] r_y;
    logic               r_wrap;

    logic [2:0]         w_state_nxt;
    logic [N_IN-1:0]    w_idx_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               w_wrap_nxt;
    logic               w_step;
    logic [c_out_w-1:0] w_onehot;
    logic [c_out_w-1:0] w_y_sel;
    logic [c_out_w-1:0] w_y_nxt;

    // The sampled mode is acted on at the same edge it is captured, so the
    // registered outputs always reflect the state entered at that edge.
    always_comb begin
        w_state_nxt = c_st_idle;
        if (bus.en) begin
            case (bus.mode)
                2'b00:   w_state_nxt = c_st_direct;
                2'b01:   w_state_nxt = c_st_scan_up;
                2'b10:   w_state_nxt = c_st_scan_dn;
                default: w_state_nxt = c_st_hold;
            endcase
        end
    end

    // ">=" rather than "==" lets a shrinking dwell_in release a counter that
    // is already past the new limit instead of running it round the wrap.
    assign w_step = (r_dwell >= bus.dwell_in);

    always_comb begin
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_wrap_nxt  = 1'b0;
        case (w_state_nxt)
            c_st_direct: begin
                w_idx_nxt   = bus.data_in;
                w_dwell_nxt = {DWELL_W{1'b0}};
            end
            c_st_scan_up, c_st_scan_dn: begin
                if (bus.load) begin
                    w_idx_nxt   = bus.data_in;
                    w_dwell_nxt = {DWELL_W{1'b0}};
                end else if (w_step) begin
                    w_dwell_nxt = {DWELL_W{1'b0}};
                    if (w_state_nxt == c_st_scan_up) begin
                        w_idx_nxt  = r_idx + c_idx_one;
                        w_wrap_nxt = (r_idx == c_idx_max);
                    end else begin
                        w_idx_nxt  = r_idx - c_idx_one;
                        w_wrap_nxt = (r_idx == c_idx_zero);
                    end
                end else begin
                    w_dwell_nxt = r_dwell + c_dwell_one;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_onehot = c_one_hot0 << w_idx_nxt;

    generate
        if (ACTIVE_LOW != 0) begin : g_pol_low
            assign w_y_sel = ~w_onehot;
        end else begin : g_pol_high
            assign w_y_sel = w_onehot;
        end
    endgenerate

    assign w_y_nxt = (w_state_nxt == c_st_idle) ? c_idle : w_y_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_idx   <= {N_IN{1'b0}};
            r_dwell <= {DWELL_W{1'b0}};
            r_y     <= c_idle;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_y     <= w_y_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign bus.y_out     = r_y;
    assign bus.idx_out   = r_idx;
    assign bus.valid_out = (r_state != c_st_idle);
    assign bus.wrap_out  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq_nto2n.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_seq_nto2n
// Brief    : Directed self-checking bench for decoder_seq_nto2n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_seq_nto2n;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decoder_seq_nto2n_if #(.N_IN(3), .DWELL_W(4)) bus ();
    decoder_seq_nto2n #(.N_IN(3), .DWELL_W(4), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    decoder_seq_nto2n_if #(.N_IN(2), .DWELL_W(3)) bus_al ();
    decoder_seq_nto2n #(.N_IN(2), .DWELL_W(3), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .rst(rst), .bus(bus_al)
    );

    decoder_seq_nto2n_if #(.N_IN(4), .DWELL_W(2)) bus4 ();
    decoder_seq_nto2n #(.N_IN(4), .DWELL_W(2), .ACTIVE_LOW(0)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_direct(input logic [2:0] idx);
        bus.en = 1'b1; bus.mode = 2'b00; bus.load = 1'b0; bus.data_in = idx;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1; bus.mode = 2'b01; bus.dwell_in = 4'd0;
        bus_al.en = 1'b1; bus_al.mode = 2'b01;
        tick(); tick();
        checks += 5;
        if (bus.y_out !== 8'h00) begin failures++; $display("FAIL reset_y actual=%h expected=00", bus.y_out); end
        if (bus.idx_out !== 3'd0) begin failures++; $display("FAIL reset_idx actual=%0d expected=0", bus.idx_out); end
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", bus.valid_out); end
        if (bus.wrap_out !== 1'b0) begin failures++; $display("FAIL reset_wrap actual=%b expected=0", bus.wrap_out); end
        if (bus_al.y_out !== 4'hF) begin failures++; $display("FAIL reset_y_al actual=%h expected=F", bus_al.y_out); end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        logic [7:0] exp_y;
        logic [3:0] exp_al;
        bus_al.en = 1'b1; bus_al.mode = 2'b00; bus_al.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.en = 1'b1; bus.mode = 2'b00; bus.data_in = 3'(i);
            bus_al.data_in = 2'(i);
            tick();
            exp_y  = 8'h01 << i;
            exp_al = ~(4'h1 << (i % 4));
            checks += 3;
            if (bus.y_out !== exp_y) begin failures++; $display("FAIL direct_y[%0d] actual=%h expected=%h", i, bus.y_out, exp_y); end
            if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL direct_valid[%0d] actual=%b expected=1", i, bus.valid_out); end
            if (bus_al.y_out !== exp_al) begin failures++; $display("FAIL direct_y_al[%0d] actual=%h expected=%h", i, bus_al.y_out, exp_al); end
        end
        bus.en = 1'b0; bus_al.en = 1'b0;
        tick();
        checks += 4;
        if (bus.y_out !== 8'h00) begin failures++; $display("FAIL idle_y actual=%h expected=00", bus.y_out); end
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL idle_valid actual=%b expected=0", bus.valid_out); end
        if (bus.idx_out !== 3'd7) begin failures++; $display("FAIL idle_idx_kept actual=%0d expected=7", bus.idx_out); end
        if (bus_al.y_out !== 4'hF) begin failures++; $display("FAIL idle_y_al actual=%h expected=F", bus_al.y_out); end
    endtask

    task automatic test_scan_up();
        logic [2:0] exp_idx [3] = '{3'd7, 3'd0, 3'd1};
        logic       exp_wrp [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0] exp_dw  [9] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        go_direct(3'd6);
        bus.mode = 2'b01; bus.dwell_in = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (bus.idx_out !== exp_idx[i]) begin failures++; $display("FAIL up_idx[%0d] actual=%0d expected=%0d", i, bus.idx_out, exp_idx[i]); end
            if (bus.wrap_out !== exp_wrp[i]) begin failures++; $display("FAIL up_wrap[%0d] actual=%b expected=%b", i, bus.wrap_out, exp_wrp[i]); end
            if (bus.y_out !== (8'h01 << exp_idx[i])) begin failures++; $display("FAIL up_y[%0d] actual=%h", i, bus.y_out); end
        end
        bus.dwell_in = 4'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (bus.idx_out !== exp_dw[i]) begin failures++; $display("FAIL up_dwell2_idx[%0d] actual=%0d expected=%0d", i, bus.idx_out, exp_dw[i]); end
        end
    endtask

    task automatic test_scan_dn();
        logic [2:0] exp_idx [3] = '{3'd0, 3'd7, 3'd6};
        logic       exp_wrp [3] = '{1'b0, 1'b1, 1'b0};
        go_direct(3'd1);
        bus.mode = 2'b10; bus.dwell_in = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (bus.idx_out !== exp_idx[i]) begin failures++; $display("FAIL dn_idx[%0d] actual=%0d expected=%0d", i, bus.idx_out, exp_idx[i]); end
            if (bus.wrap_out !== exp_wrp[i]) begin failures++; $display("FAIL dn_wrap[%0d] actual=%b expected=%b", i, bus.wrap_out, exp_wrp[i]); end
        end
        bus.load = 1'b1; bus.data_in = 3'd5;
        tick();
        checks += 2;
        if (bus.idx_out !== 3'd5) begin failures++; $display("FAIL dn_load_idx actual=%0d expected=5", bus.idx_out); end
        if (bus.wrap_out !== 1'b0) begin failures++; $display("FAIL dn_load_wrap actual=%b expected=0", bus.wrap_out); end
        bus.load = 1'b0;
        tick();
        checks++;
        if (bus.idx_out !== 3'd4) begin failures++; $display("FAIL dn_after_load actual=%0d expected=4", bus.idx_out); end
        // Loading 0 while scanning down must not itself raise wrap.
        bus.load = 1'b1; bus.data_in = 3'd0;
        tick();
        checks++;
        if (bus.wrap_out !== 1'b0) begin failures++; $display("FAIL dn_load0_wrap actual=%b expected=0", bus.wrap_out); end
        bus.load = 1'b0;
    endtask

    task automatic test_hold();
        go_direct(3'd3);
        bus.mode = 2'b11; bus.load = 1'b1; bus.data_in = 3'd6;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks += 2;
            if (bus.y_out !== 8'h08) begin failures++; $display("FAIL hold_y[%0d] actual=%h expected=08", i, bus.y_out); end
            if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] actual=%b expected=1", i, bus.valid_out); end
        end
        bus.load = 1'b0; bus.mode = 2'b01; bus.dwell_in = 4'd0;
        tick();
        checks++;
        if (bus.idx_out !== 3'd4) begin failures++; $display("FAIL hold_resume_idx actual=%0d expected=4", bus.idx_out); end
    endtask

    task automatic test_reset_mid_scan();
        go_direct(3'd0);
        bus.mode = 2'b01; bus.dwell_in = 4'd3;
        tick(); tick();
        rst = 1'b1;
        tick();
        checks += 4;
        if (bus.y_out !== 8'h00) begin failures++; $display("FAIL rstmid_y actual=%h expected=00", bus.y_out); end
        if (bus.idx_out !== 3'd0) begin failures++; $display("FAIL rstmid_idx actual=%0d expected=0", bus.idx_out); end
        if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_valid actual=%b expected=0", bus.valid_out); end
        if (bus.wrap_out !== 1'b0) begin failures++; $display("FAIL rstmid_wrap actual=%b expected=0", bus.wrap_out); end
        rst = 1'b0;
        // Dwell counter restarts at 0, so the first step takes four edges.
        tick(); tick(); tick();
        checks++;
        if (bus.idx_out !== 3'd0) begin failures++; $display("FAIL rstmid_dwell_hold actual=%0d expected=0", bus.idx_out); end
        tick();
        checks++;
        if (bus.idx_out !== 3'd1) begin failures++; $display("FAIL rstmid_dwell_step actual=%0d expected=1", bus.idx_out); end
    endtask

    task automatic test_dwell_shrink();
        go_direct(3'd2);
        bus.mode = 2'b01; bus.dwell_in = 4'd7;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.idx_out !== 3'd2) begin failures++; $display("FAIL shrink_pre actual=%0d expected=2", bus.idx_out); end
        bus.dwell_in = 4'd2;
        tick();
        checks++;
        if (bus.idx_out !== 3'd3) begin failures++; $display("FAIL shrink_step actual=%0d expected=3", bus.idx_out); end
        tick(); tick();
        checks++;
        if (bus.idx_out !== 3'd3) begin failures++; $display("FAIL shrink_dwell actual=%0d expected=3", bus.idx_out); end
        tick();
        checks++;
        if (bus.idx_out !== 3'd4) begin failures++; $display("FAIL shrink_next actual=%0d expected=4", bus.idx_out); end
    endtask

    task automatic test_random_invariant();
        logic [7:0]  exp8;
        logic [3:0]  exp4;
        logic [15:0] exp16;
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.en = ($urandom_range(0, 7) != 0);   bus.mode = 2'($urandom);
            bus.load = ($urandom_range(0, 7) == 0); bus.data_in = 3'($urandom);
            bus.dwell_in = 4'($urandom_range(0, 3));
            bus_al.en = ($urandom_range(0, 7) != 0);   bus_al.mode = 2'($urandom);
            bus_al.load = ($urandom_range(0, 7) == 0); bus_al.data_in = 2'($urandom);
            bus_al.dwell_in = 3'($urandom_range(0, 3));
            bus4.en = ($urandom_range(0, 7) != 0);   bus4.mode = 2'($urandom);
            bus4.load = ($urandom_range(0, 7) == 0); bus4.data_in = 4'($urandom);
            bus4.dwell_in = 2'($urandom);
            tick();
            exp8  = bus.valid_out ? (8'h01 << bus.idx_out) : 8'h00;
            exp4  = bus_al.valid_out ? ~(4'h1 << bus_al.idx_out) : 4'hF;
            exp16 = bus4.valid_out ? (16'h0001 << bus4.idx_out) : 16'h0000;
            checks += 3;
            if (bus.y_out !== exp8) begin failures++; $display("FAIL rand_n3[%0d] actual=%h expected=%h", i, bus.y_out, exp8); end
            if (bus_al.y_out !== exp4) begin failures++; $display("FAIL rand_n2_al[%0d] actual=%h expected=%h", i, bus_al.y_out, exp4); end
            if (bus4.y_out !== exp16) begin failures++; $display("FAIL rand_n4[%0d] actual=%h expected=%h", i, bus4.y_out, exp16); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.mode = 2'b00; bus.data_in = '0; bus.load = 1'b0; bus.dwell_in = '0;
        bus_al.en = 1'b0; bus_al.mode = 2'b00; bus_al.data_in = '0; bus_al.load = 1'b0; bus_al.dwell_in = '0;
        bus4.en = 1'b0; bus4.mode = 2'b00; bus4.data_in = '0; bus4.load = 1'b0; bus4.dwell_in = '0;
        test_reset();
        test_direct();
        test_scan_up();
        test_scan_dn();
        test_hold();
        test_reset_mid_scan();
        test_dwell_shrink();
        test_random_invariant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
